// File: rtl/bwt_pkg.sv
// Shared definitions for the BWT prefix-doubling pipeline: key field layout,
// byte width, key triplet type and the sort/rank controller states.
package bwt_pkg;

  localparam int KEY_IDX = 2;
  localparam int KEY_B1  = 1;
  localparam int KEY_B0  = 0;
  localparam int BYTE_W  = 8;

  typedef logic [BYTE_W-1:0] key_t [2:0];

  typedef enum logic [2:0] {IDLE, LOAD, SORT, RANK, DONE} state_t;

  // Strict total order: buckets first, suffix index breaks ties.
  function automatic logic key_gt(input key_t a, input key_t b);
    logic [2*BYTE_W-1:0] ba;
    logic [2*BYTE_W-1:0] bb;
    ba = {a[KEY_B1], a[KEY_B0]};
    bb = {b[KEY_B1], b[KEY_B0]};
    if (ba != bb) return ba > bb;
    return a[KEY_IDX] > b[KEY_IDX];
  endfunction

endpackage

// File: rtl/key_cmp_swap.sv
// Combinational compare-and-swap of two key triplets; lo receives the smaller
// key when enabled, otherwise the inputs pass straight through.
module key_cmp_swap
  import bwt_pkg::*;
(
  input  logic en,
  input  key_t a,
  input  key_t b,
  output key_t lo,
  output key_t hi
);

  logic swap;

  assign swap = en && key_gt(a, b);

  always_comb begin
    for (int f = 0; f < 3; f++) begin
      lo[f] = swap ? b[f] : a[f];
      hi[f] = swap ? a[f] : b[f];
    end
  end

endmodule

// File: rtl/sort_rank_keys.sv
// Sorts STRING_LEN key triplets with an odd-even transposition network (one
// pass per cycle), then walks the sorted list assigning dense bucket ranks.
module sort_rank_keys
  import bwt_pkg::*;
#(
  parameter int STRING_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] keys_in     [0:STRING_LEN-1][2:0],
  output logic [BYTE_W-1:0] sa_out      [0:STRING_LEN-1],
  output logic [BYTE_W-1:0] buckets_out [0:STRING_LEN-1],
  output logic              all_unique,
  output logic              done
);

  localparam int              IDX_W = (STRING_LEN > 2) ? $clog2(STRING_LEN) : 1;
  localparam logic [BYTE_W-1:0] LAST  = 8'(STRING_LEN - 1);
  localparam logic [BYTE_W-1:0] LEN   = 8'(STRING_LEN);

  state_t            state_reg;
  logic [BYTE_W-1:0] cnt_reg;
  logic [BYTE_W-1:0] rank_reg;
  logic [BYTE_W-1:0] rank_next;
  key_t              key_reg  [0:STRING_LEN-1];
  key_t              key_next [0:STRING_LEN-1];
  key_t              lo       [0:STRING_LEN-2];
  key_t              hi       [0:STRING_LEN-2];
  logic [STRING_LEN-2:0] pair_en;

  // Pair (gi, gi+1) is active on passes whose parity matches gi.
  generate
    for (genvar gi = 0; gi < STRING_LEN - 1; gi++) begin : g_cs
      assign pair_en[gi] = (state_reg == SORT) && (cnt_reg[0] == 1'(gi % 2));
      key_cmp_swap u_cs (
        .en (pair_en[gi]),
        .a  (key_reg[gi]),
        .b  (key_reg[gi+1]),
        .lo (lo[gi]),
        .hi (hi[gi])
      );
    end
  endgenerate

  always_comb begin
    key_next = key_reg;
    for (int j = 0; j < STRING_LEN - 1; j++) begin
      if (pair_en[j]) begin
        key_next[j]   = lo[j];
        key_next[j+1] = hi[j];
      end
    end
  end

  logic [IDX_W-1:0]  cur;
  logic [IDX_W-1:0]  prv;
  logic [BYTE_W-1:0] cur_idx;
  logic              bucket_changed;

  assign cur            = cnt_reg[IDX_W-1:0];
  assign prv            = cur - 1'b1;
  assign cur_idx        = key_reg[cur][KEY_IDX];
  assign bucket_changed = {key_reg[cur][KEY_B1], key_reg[cur][KEY_B0]} !=
                          {key_reg[prv][KEY_B1], key_reg[prv][KEY_B0]};
  assign rank_next      = (cnt_reg == '0) ? 8'd1 :
                          (bucket_changed ? rank_reg + 8'd1 : rank_reg);

  always_ff @(posedge clk) begin
    if (state_reg == LOAD) begin
      for (int k = 0; k < STRING_LEN; k++) begin
        for (int f = 0; f < 3; f++) key_reg[k][f] <= keys_in[k][f];
      end
    end else if (state_reg == SORT) begin
      key_reg <= key_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      rank_reg   <= '0;
      all_unique <= 1'b0;
      done       <= 1'b0;
      for (int k = 0; k < STRING_LEN; k++) begin
        sa_out[k]      <= '0;
        buckets_out[k] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: if (start) state_reg <= LOAD;
        LOAD: begin
          cnt_reg    <= '0;
          rank_reg   <= '0;
          all_unique <= 1'b0;
          for (int k = 0; k < STRING_LEN; k++) begin
            sa_out[k]      <= '0;
            buckets_out[k] <= '0;
          end
          state_reg <= SORT;
        end
        SORT: begin
          if (cnt_reg == LAST) begin
            cnt_reg   <= '0;
            state_reg <= RANK;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        RANK: begin
          sa_out[cur] <= cur_idx;
          // Out-of-range indices are undefined input; their write is dropped.
          if (cur_idx < LEN) buckets_out[cur_idx[IDX_W-1:0]] <= rank_next;
          rank_reg <= rank_next;
          if (cnt_reg == LAST) begin
            cnt_reg    <= '0;
            all_unique <= (rank_next == LEN);
            done       <= 1'b1;
            state_reg  <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        DONE: begin
          if (start) begin
            done      <= 1'b0;
            state_reg <= LOAD;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_rank_keys.sv
// Scoreboard bench: stimulus pushes expected results, monitors pop and compare
// on each rising done of an 8-key and a 2-key instance.
module tb_sort_rank_keys;
  import bwt_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] keys_in [0:7][2:0];
  logic [7:0] sa_out [0:7];
  logic [7:0] buckets_out [0:7];
  logic       all_unique, done;

  logic [7:0] keys2 [0:1][2:0];
  logic [7:0] sa2 [0:1];
  logic [7:0] bk2 [0:1];
  logic       uniq2, done2;

  sort_rank_keys #(.STRING_LEN(8)) dut (
    .clk(clk), .rst(rst), .start(start), .keys_in(keys_in),
    .sa_out(sa_out), .buckets_out(buckets_out), .all_unique(all_unique), .done(done));

  sort_rank_keys #(.STRING_LEN(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .keys_in(keys2),
    .sa_out(sa2), .buckets_out(bk2), .all_unique(uniq2), .done(done2));

  typedef struct {
    int id;
    int sa[8];
    int bk[8];
    int uniq;
    int start_cyc;
    int lat;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   done_d = 1'b0;
  bit   done2_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp_v);
    end
  endtask

  always @(negedge clk) begin : mon8
    exp_t e;
    if (done && !done_d) begin
      if (q1.size() == 0) begin
        chk("unexpected_done_n8", 1, 0);
      end else begin
        e = q1.pop_front();
        for (int i = 0; i < 8; i++) begin
          chk($sformatf("t%0d_sa[%0d]", e.id, i), int'(sa_out[i]), e.sa[i]);
          chk($sformatf("t%0d_bk[%0d]", e.id, i), int'(buckets_out[i]), e.bk[i]);
        end
        chk($sformatf("t%0d_all_unique", e.id), int'(all_unique), e.uniq);
        chk($sformatf("t%0d_latency", e.id), cyc - e.start_cyc, e.lat);
        $display("txn %0d n=8 latency=%0d all_unique=%0d", e.id, cyc - e.start_cyc, all_unique);
      end
    end
    done_d = done;
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (done2 && !done2_d) begin
      if (q2.size() == 0) begin
        chk("unexpected_done_n2", 1, 0);
      end else begin
        e = q2.pop_front();
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("t%0d_sa[%0d]", e.id, i), int'(sa2[i]), e.sa[i]);
          chk($sformatf("t%0d_bk[%0d]", e.id, i), int'(bk2[i]), e.bk[i]);
        end
        chk($sformatf("t%0d_all_unique", e.id), int'(uniq2), e.uniq);
        chk($sformatf("t%0d_latency", e.id), cyc - e.start_cyc, e.lat);
        $display("txn %0d n=2 latency=%0d all_unique=%0d", e.id, cyc - e.start_cyc, uniq2);
      end
    end
    done2_d = done2;
  end

  task automatic set8(input int idx[8], input int b1[8], input int b0[8]);
    for (int i = 0; i < 8; i++) begin
      keys_in[i][KEY_IDX] = 8'(idx[i]);
      keys_in[i][KEY_B1]  = 8'(b1[i]);
      keys_in[i][KEY_B0]  = 8'(b0[i]);
    end
  endtask

  task automatic issue8(input int id, input int esa[8], input int ebk[8], input int eu);
    exp_t e;
    e.id = id; e.sa = esa; e.bk = ebk; e.uniq = eu;
    e.start_cyc = cyc + 1; e.lat = 17;
    q1.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_q1(input string nm);
    int k;
    for (k = 0; k < 100 && q1.size() != 0; k++) @(negedge clk);
    if (q1.size() != 0) begin
      chk({nm, "_timeout"}, q1.size(), 0);
      q1.delete();
    end
    @(negedge clk);
  endtask

  int pos[8], zero[8], desc[8], asc[8], tie_b0[8], five[8];
  int sa_desc[8], sa_tie[8], bk_tie[8];

  initial begin : stim
    exp_t e2;
    int k;
    for (int i = 0; i < 8; i++) begin
      pos[i] = i; zero[i] = 0; desc[i] = 8 - i; asc[i] = i + 1; five[i] = 5;
      sa_desc[i] = 7 - i;
    end
    tie_b0 = '{0, 3, 3, 1, 0, 3, 1, 0};
    sa_tie = '{0, 4, 7, 3, 6, 1, 2, 5};
    bk_tie = '{1, 3, 3, 2, 1, 3, 2, 1};
    set8(pos, zero, zero);
    for (int i = 0; i < 2; i++) begin
      keys2[i][KEY_IDX] = 8'(i);
      keys2[i][KEY_B1]  = 8'd9;
      keys2[i][KEY_B0]  = 8'd0;
    end

    repeat (3) @(negedge clk);
    chk("rst_done", int'(done), 0);
    chk("rst_all_unique", int'(all_unique), 0);
    chk("rst_done_n2", int'(done2), 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rst_sa[%0d]", i), int'(sa_out[i]), 0);
      chk($sformatf("rst_bk[%0d]", i), int'(buckets_out[i]), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Distinct descending buckets
    set8(pos, desc, zero);
    issue8(1, sa_desc, desc, 1);
    wait_q1("t1");

    // Equal primaries, tied secondaries
    set8(pos, five, tie_b0);
    issue8(2, sa_tie, bk_tie, 0);
    wait_q1("t2");

    // Already sorted: still a full 17-cycle run
    set8(pos, asc, zero);
    issue8(3, pos, asc, 1);
    wait_q1("t3");

    // start during SORT must be ignored
    set8(pos, five, tie_b0);
    issue8(4, sa_tie, bk_tie, 0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_q1("t4");

    // Restart from DONE: done drops after the sampling edge
    set8(pos, desc, zero);
    issue8(5, sa_desc, desc, 1);
    chk("t5_done_fall", int'(done), 0);
    wait_q1("t5");

    // Reset in the middle of RANK discards everything
    set8(pos, asc, zero);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_done", int'(done), 0);
    chk("t6_rst_all_unique", int'(all_unique), 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t6_rst_sa[%0d]", i), int'(sa_out[i]), 0);
      chk($sformatf("t6_rst_bk[%0d]", i), int'(buckets_out[i]), 0);
    end
    repeat (3) @(negedge clk);
    chk("t6_idle_no_done", int'(done), 0);
    issue8(7, pos, asc, 1);
    wait_q1("t7");

    // Two-key instance, equal buckets
    e2.id = 8; e2.sa = '{0, 1, 0, 0, 0, 0, 0, 0}; e2.bk = '{1, 1, 0, 0, 0, 0, 0, 0};
    e2.uniq = 0; e2.start_cyc = cyc + 1; e2.lat = 5;
    q2.push_back(e2);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (k = 0; k < 50 && q2.size() != 0; k++) @(negedge clk);
    if (q2.size() != 0) chk("t8_timeout", q2.size(), 0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sort_rank_keys.md
# sort_rank_keys

Downstream stage of the key builder in the BWT prefix-doubling loop. Captures the STRING_LEN key triplets {index, bucket, bucket-at-offset} and sorts them with an odd-even transposition network, one pass per cycle. It then walks the sorted list to assign new dense bucket ranks. The outputs are the suffix order, the re-ranked buckets that feed the next doubling round, and a flag that tells the controller when every rank is unique and the loop can stop.

## Interface
Parameters:
- STRING_LEN, 8: number of keys/characters; legal range 2..254.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE or DONE
- keys_in  in  8 x [0:STRING_LEN-1][2:0]  key triplets; [2]=index, [1]=primary bucket, [0]=secondary bucket (0 = past end)
- sa_out  out  8 x [0:STRING_LEN-1]  sorted suffix indices
- buckets_out  out  8 x [0:STRING_LEN-1]  new rank per original index, ranks start at 1
- all_unique  out  1  high when the final rank equals STRING_LEN; valid while done
- done  out  1  level; high in DONE state only

## Operation
- States:
  - IDLE: start -> LOAD.
  - LOAD: always -> SORT.
  - SORT: after pass STRING_LEN-1 -> RANK.
  - RANK: after element STRING_LEN-1 -> DONE.
  - DONE: start -> LOAD, else hold.
- LOAD: copy keys_in into internal array key[0..N-1]. Clear pass counter, rank counter, sa_out, buckets_out and all_unique.
- Ordering: key A is greater than key B if {A[1],A[0]} > {B[1],B[0]} unsigned. On a tie, A is greater if A[2] > B[2]. This is a strict total order, so the result is deterministic.
- SORT, pass p:
  - p even: compare and swap pairs (0,1),(2,3),...
  - p odd: compare and swap pairs (1,2),(3,4),...
  - A pair is swapped if the lower slot is greater than the upper slot.
  - Exactly STRING_LEN passes. No early exit.
- RANK, element i, one per cycle:
  - i = 0: rank = 1.
  - i > 0: rank increments if {key[i][1],key[i][0]} differs from that of key[i-1]; otherwise rank is unchanged. The index field is ignored here.
  - sa_out[i] <= key[i][2].
  - buckets_out[key[i][2]] <= rank.
- On entering DONE: all_unique <= (rank == STRING_LEN).
- start outside IDLE/DONE is ignored. start in DONE restarts the block: done falls on the next edge and outputs clear in LOAD.
- Width rules:
  - All counters are 8 bit.
  - The pass counter compares against STRING_LEN-1.
  - Rank never exceeds STRING_LEN, so it never overflows.
- Index values ≥ STRING_LEN in keys_in are undefined input. The write to buckets_out is dropped if the index is out of range.

## Timing
- Reset values: sa_out all 0, buckets_out all 0, all_unique 0, done 0. State is IDLE; all counters are 0.
- Reset mid-operation: the block returns to IDLE on that edge, all outputs clear, and any partial sort is discarded.
- Cycle sequence, with edge 0 the edge that samples start:
  - edge 1: LOAD captures keys_in.
  - edges 2..N+1: sort passes 0..N-1.
  - edges N+2..2N+1: rank elements 0..N-1.
  - done is high after edge 2N+1. Latency is 2N+1 cycles; for N=8, done is high 17 cycles after start.
- keys_in must be stable only at edge 1.
- Outputs are registered and hold unchanged while in DONE.
- sa_out and buckets_out are partially written during RANK. They are valid only when done is high.

## Structure
- Shared package bwt_pkg:
  - KEY_IDX=2, KEY_B1=1, KEY_B0=0
  - BYTE_W=8
  - typedef key_t (3 x 8-bit unpacked triplet)
  - state enum {IDLE, LOAD, SORT, RANK, DONE}
  - The key builder imports the same field constants.
- One sub-module, key_cmp_swap: a purely combinational compare-and-swap of two key_t values, instantiated STRING_LEN-1 times. An enable selects even or odd pairs.

## Test plan
- Distinct keys: buckets {8,7,6,5,4,3,2,1}, secondaries 0, index = position -> sa_out={7,6,5,4,3,2,1,0}; buckets_out[i]=8-i; all_unique=1; done exactly 17 cycles after start.
- Ties: all primaries 5, secondaries {0,3,3,1,0,3,1,0} -> sa_out={0,4,7,3,6,1,2,5}; ranks {1,3,3,2,1,3,2,1}; all_unique=0.
- Already sorted input (primaries 1..8) -> sa_out identity; ranks 1..8; same 17-cycle latency, with no early exit.
- start pulsed during SORT -> ignored; a single done at cycle 17. start pulsed in DONE -> done low next cycle, and the new result appears 17 cycles later.
- rst asserted mid-RANK -> next cycle: done=0, all outputs 0, state IDLE. A subsequent start yields the correct result.
- STRING_LEN=2, keys {1:(1,9,0), 0:(0,9,0)} -> sa_out={0,1}, ranks {1,1}, all_unique=0, latency 5.
